misr_signature_analyzer: RTL and testbench



---
 rtl/bist_pkg.sv | 15 +
 rtl/misr_core.sv | 47 ++++
 rtl/misr_signature_analyzer.sv | 112 +++++++++++
 tb/tb_misr_signature_analyzer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/bist_pkg.sv
// Shared BIST definitions: default LFSR/MISR geometry and the analyzer controller states.
package bist_pkg;

    localparam int         MISR_WIDTH = 9;
    localparam logic [8:0] MISR_TAPS  = 9'h021;
    localparam logic [8:0] MISR_SEED  = 9'h000;
    localparam int         MISR_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/misr_core.sv
// Galois-style multiple-input signature register with a synchronous seed load and word enable.
module misr_core
    import bist_pkg::*;
#(
    parameter int               WIDTH = MISR_WIDTH,
    parameter logic [WIDTH-1:0] TAPS  = MISR_TAPS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] seed_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] sig_o,
    output logic [WIDTH-1:0] sig_next_o
);

    logic [WIDTH-1:0] sig_q;
    logic [WIDTH-1:0] sig_d;
    logic [WIDTH-1:0] upd;
    logic             fb;

    assign fb = sig_q[WIDTH-1];

    always_comb begin
        // Shift with feedback folded into the tapped bits, then absorb the input word.
        upd   = {sig_q[WIDTH-2:0], 1'b0} ^ (TAPS & {WIDTH{fb}}) ^ din_i;
        sig_d = sig_q;
        if (load_i) begin
            sig_d = seed_i;
        end else if (en_i) begin
            sig_d = upd;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig_o      = sig_q;
    assign sig_next_o = upd;

endmodule

// File: rtl/misr_signature_analyzer.sv
// BIST response compactor: counts a programmed number of valid words into a MISR, then grades the signature.
// Handshake: din is consumed on any RUN cycle with din_valid high; there is no backpressure.
module misr_signature_analyzer
    import bist_pkg::*;
#(
    parameter int               WIDTH = MISR_WIDTH,
    parameter logic [WIDTH-1:0] TAPS  = MISR_TAPS,
    parameter logic [WIDTH-1:0] SEED  = MISR_SEED,
    parameter int               CNT_W = MISR_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] num_pat,
    input  logic             din_valid,
    input  logic [WIDTH-1:0] din,
    input  logic [WIDTH-1:0] golden,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH-1:0] signature,
    output logic [CNT_W-1:0] count,
    output state_t           dbg_state
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] num_q, num_d;
    logic             pass_q, pass_d;
    logic             misr_load;
    logic             misr_en;
    logic [WIDTH-1:0] sig_cur;
    logic [WIDTH-1:0] sig_next;
    logic             last_word;

    misr_core #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS)
    ) u_misr (
        .clk        (clk),
        .reset      (reset),
        .load_i     (misr_load),
        .seed_i     (SEED),
        .en_i       (misr_en),
        .din_i      (din),
        .sig_o      (sig_cur),
        .sig_next_o (sig_next)
    );

    // Compare against the incremented count so no subtraction wraps for a large num_pat.
    assign last_word = ((cnt_q + CNT_W'(1)) == num_q);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        num_d     = num_q;
        pass_d    = pass_q;
        misr_load = 1'b0;
        misr_en   = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    misr_load = 1'b1;
                    cnt_d     = '0;
                    num_d     = num_pat;
                    if (num_pat == '0) begin
                        state_d = ST_DONE;
                        pass_d  = (SEED == golden);
                    end else begin
                        state_d = ST_RUN;
                        pass_d  = 1'b0;
                    end
                end
            end
            ST_RUN: begin
                if (din_valid) begin
                    misr_en = 1'b1;
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (last_word) begin
                        state_d = ST_DONE;
                        pass_d  = (sig_next == golden);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            num_q   <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            num_q   <= num_d;
            pass_q  <= pass_d;
        end
    end

    assign busy      = (state_q == ST_RUN);
    assign done      = (state_q == ST_DONE);
    assign pass      = pass_q;
    assign signature = sig_cur;
    assign count     = cnt_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_misr_signature_analyzer.sv
// Self-checking bench: polynomial-arithmetic reference model, per-cycle compare, directed and random runs.
module tb_misr_signature_analyzer;
  import bist_pkg::*;

  localparam int W = 9;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [CW-1:0] num_pat = '0;
  logic          din_valid = 1'b0;
  logic [W-1:0]  din = '0;
  logic [W-1:0]  golden = '0;
  logic          busy, done, pass;
  logic [W-1:0]  signature;
  logic [CW-1:0] count;
  state_t        dbg_state;

  int n_checks = 0;
  int n_fail = 0;
  logic chk_en = 1'b0;

  misr_signature_analyzer dut (
    .clk(clk), .reset(reset), .start(start), .num_pat(num_pat),
    .din_valid(din_valid), .din(din), .golden(golden),
    .busy(busy), .done(done), .pass(pass), .signature(signature),
    .count(count), .dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // reference model: signature as a polynomial over GF(2) modulo x^9+x^5+1
  int           m_mode;  // 0 idle, 1 running, 2 finished
  logic [W-1:0] m_sig;
  int           m_cnt;
  int           m_num;
  logic         m_pass;

  function automatic logic [W-1:0] poly_step(input logic [W-1:0] s, input logic [W-1:0] d);
    logic [W:0] t;
    t = {s, 1'b0};
    if (t[W]) t = t ^ 10'h221;
    return t[W-1:0] ^ d;
  endfunction

  logic [W-1:0] wbuf[$];

  function automatic logic [W-1:0] fold_words(input int n);
    logic [W-1:0] s;
    s = 9'h000;
    for (int i = 0; i < n; i++) s = poly_step(s, wbuf[i]);
    return s;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_mode = 0; m_sig = '0; m_cnt = 0; m_num = 0; m_pass = 1'b0;
    end else if (m_mode != 1) begin
      if (start) begin
        m_sig = 9'h000; m_cnt = 0; m_num = int'(num_pat);
        if (m_num == 0) begin
          m_mode = 2; m_pass = (golden == 9'h000);
        end else begin
          m_mode = 1; m_pass = 1'b0;
        end
      end
    end else if (din_valid) begin
      m_sig = poly_step(m_sig, din);
      m_cnt = m_cnt + 1;
      if (m_cnt == m_num) begin
        m_mode = 2; m_pass = (m_sig == golden);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // compare process, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_sig", 32'(signature), 32'(m_sig));
      check("cyc_count", 32'(count), 32'(m_cnt));
      check("cyc_busy", 32'(busy), 32'(m_mode == 1));
      check("cyc_done", 32'(done), 32'(m_mode == 2));
      check("cyc_pass", 32'(pass), 32'(m_pass));
      check("cyc_state", 32'(dbg_state), 32'(m_mode));
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #2;
    start = 1'b0;
    din_valid = 1'b0;
  endtask

  task automatic do_start(input int np, input logic [W-1:0] g);
    num_pat = CW'(np);
    golden = g;
    start = 1'b1;
    tick();
  endtask

  task automatic feed(input logic [W-1:0] w, input int gap, input bit noisy);
    for (int i = 0; i < gap; i++) begin
      din = W'($urandom);
      start = noisy ? 1'($urandom) : 1'b0;
      tick();
    end
    din = w;
    din_valid = 1'b1;
    tick();
  endtask

  task automatic scenario1();
    do_start(2, 9'h002);
    feed(9'h001, 0, 0);
    feed(9'h000, 0, 0);
    check("s1_sig", 32'(signature), 32'h002);
    check("s1_count", 32'(count), 32'd2);
    check("s1_done", 32'(done), 32'd1);
    check("s1_pass", 32'(pass), 32'd1);
  endtask

  initial begin
    logic [W-1:0] lf;
    logic [W-1:0] gold;
    int np;

    // reset held two cycles
    reset = 1'b1;
    tick();
    tick();
    chk_en = 1'b1;
    check("rst_sig", 32'(signature), 32'h0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;

    scenario1();

    // walking one reaches the MSB, then feedback fires
    do_start(9, 9'h000);
    feed(9'h001, 0, 0);
    for (int i = 0; i < 8; i++) feed(9'h000, 0, 0);
    check("s2_sig9", 32'(signature), 32'h100);
    do_start(10, 9'h000);
    feed(9'h001, 0, 0);
    for (int i = 0; i < 9; i++) feed(9'h000, 0, 0);
    check("s2_sig10", 32'(signature), 32'h021);

    // gaps between valid words
    do_start(2, 9'h002);
    feed(9'h001, 0, 0);
    for (int i = 0; i < 3; i++) begin
      din = W'($urandom);
      tick();
      check("s3_gap_busy", 32'(busy), 32'd1);
      check("s3_gap_done", 32'(done), 32'd0);
    end
    feed(9'h000, 0, 0);
    check("s3_sig", 32'(signature), 32'h002);
    check("s3_done", 32'(done), 32'd1);

    // zero-length runs
    do_start(0, 9'h000);
    check("s4_done", 32'(done), 32'd1);
    check("s4_pass", 32'(pass), 32'd1);
    check("s4_count", 32'(count), 32'd0);
    do_start(0, 9'h001);
    check("s4_pass_bad", 32'(pass), 32'd0);

    // reset mid-run
    do_start(5, 9'h000);
    for (int i = 0; i < 3; i++) feed(W'($urandom), 0, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("s5_sig", 32'(signature), 32'h0);
    check("s5_count", 32'(count), 32'd0);
    check("s5_busy", 32'(busy), 32'd0);
    check("s5_state", 32'(dbg_state), 32'(ST_IDLE));
    scenario1();

    // chained with an x^9+x^5+1 Galois LFSR, 511 words
    wbuf.delete();
    lf = 9'h001;
    for (int i = 0; i < 511; i++) begin
      wbuf.push_back(lf);
      lf = {lf[7:0], 1'b0} ^ (lf[8] ? 9'h021 : 9'h000);
    end
    gold = fold_words(511);
    do_start(511, gold);
    for (int i = 0; i < 511; i++) feed(wbuf[i], 0, 0);
    check("s6_pass", 32'(pass), 32'd1);
    do_start(511, gold);
    for (int i = 0; i < 511; i++) feed(wbuf[i] ^ ((i == 200) ? 9'h001 : 9'h000), 0, 0);
    check("s6_flip_pass", 32'(pass), 32'd0);

    // randomized runs with gaps, ignored starts, junk data and occasional resets
    for (int r = 0; r < 40; r++) begin
      np = $urandom_range(1, 30);
      wbuf.delete();
      for (int i = 0; i < np; i++) wbuf.push_back(W'($urandom));
      gold = ($urandom_range(0, 1) == 1) ? fold_words(np) : W'($urandom);
      do_start(np, gold);
      for (int i = 0; i < np; i++) begin
        if (r % 9 == 4 && i == np / 2) begin
          reset = 1'b1;
          tick();
          reset = 1'b0;
          break;
        end
        feed(wbuf[i], $urandom_range(0, 2), 1);
        if (i == np - 1)
          check("rnd_pass", 32'(pass), 32'(gold == fold_words(np)));
      end
      for (int i = 0; i < $urandom_range(0, 3); i++) begin
        din = W'($urandom);
        din_valid = 1'($urandom);
        tick();
      end
    end

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
